// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: aligns to the frame strobe, steers each
// serial bit into its lane and presents whole frames with a one-cycle vld pulse.
module tdm_demux4 #(
  parameter int MISS_MAX = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       fs,
  input  logic       en,
  output logic       z0,
  output logic       z1,
  output logic       z2,
  output logic       z3,
  output logic       vld,
  output logic [1:0] sel,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [2:0] MISS_LIM = 3'(MISS_MAX);

  state_t     state, state_nxt;
  logic [1:0] slot, slot_nxt;
  logic [2:0] miss, miss_nxt;
  logic [2:0] miss_inc;
  logic [2:0] shadow, shadow_nxt;
  logic [3:0] lanes, lanes_nxt;
  logic       vld_q, vld_nxt;
  logic       serr_q, serr_nxt;

  assign miss_inc = miss + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HUNT;
      slot   <= 2'd0;
      miss   <= 3'd0;
      shadow <= 3'd0;
      lanes  <= 4'd0;
      vld_q  <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      slot   <= slot_nxt;
      miss   <= miss_nxt;
      shadow <= shadow_nxt;
      lanes  <= lanes_nxt;
      vld_q  <= vld_nxt;
      serr_q <= serr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    miss_nxt   = miss;
    shadow_nxt = shadow;
    lanes_nxt  = lanes;
    vld_nxt    = 1'b0;
    serr_nxt   = 1'b0;

    if (en) begin
      case (state)
        HUNT: begin
          if (fs) begin
            shadow_nxt[0] = din;
            slot_nxt      = 2'd1;
            miss_nxt      = 3'd0;
            state_nxt     = LOCKED;
          end
        end

        LOCKED: begin
          if (fs) begin
            // A strobe anywhere but slot 0 restarts the frame at this sample.
            serr_nxt   = (slot != 2'd0);
            shadow_nxt = {2'b00, din};
            slot_nxt   = 2'd1;
            miss_nxt   = 3'd0;
          end else begin
            case (slot)
              2'd0: begin
                if (miss_inc == MISS_LIM) begin
                  state_nxt  = HUNT;
                  slot_nxt   = 2'd0;
                  shadow_nxt = 3'd0;
                  miss_nxt   = 3'd0;
                end else begin
                  shadow_nxt[0] = din;
                  miss_nxt      = miss_inc;
                  slot_nxt      = 2'd1;
                end
              end
              2'd1: begin
                shadow_nxt[1] = din;
                slot_nxt      = 2'd2;
              end
              2'd2: begin
                shadow_nxt[2] = din;
                slot_nxt      = 2'd3;
              end
              default: begin
                lanes_nxt = {din, shadow};
                vld_nxt   = 1'b1;
                slot_nxt  = 2'd0;
              end
            endcase
          end
        end

        default: state_nxt = HUNT;
      endcase
    end
  end

  assign z0       = lanes[0];
  assign z1       = lanes[1];
  assign z2       = lanes[2];
  assign z3       = lanes[3];
  assign vld      = vld_q;
  assign sel      = slot;
  assign locked   = (state == LOCKED);
  assign sync_err = serr_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: frames are queued when their last bit is
// driven and compared against z0..z3 when vld appears.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       fs = 1'b0;
  logic       en = 1'b0;
  logic       z0, z1, z2, z3;
  logic       vld;
  logic [1:0] sel;
  logic       locked;
  logic       sync_err;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] last_z = 4'd0;

  tdm_demux4 #(.MISS_MAX(2)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .fs(fs), .en(en),
    .z0(z0), .z1(z1), .z2(z2), .z3(z3), .vld(vld), .sel(sel),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".z"}, 8'({z3, z2, z1, z0}), 8'h0);
    chk({tag, ".vld"}, 8'(vld), 8'h0);
    chk({tag, ".sel"}, 8'(sel), 8'h0);
    chk({tag, ".locked"}, 8'(locked), 8'h0);
    chk({tag, ".sync_err"}, 8'(sync_err), 8'h0);
  endtask

  // ez is {z3,z2,z1,z0}; push=1 marks the sample that completes a frame.
  task automatic step(input string tag, input logic e, input logic d, input logic f,
                      input logic [1:0] esel, input logic elk, input logic eserr,
                      input logic push, input logic [3:0] ez);
    logic expect_vld;
    @(negedge clk);
    en  = e;
    din = d;
    fs  = f;
    if (push) exp_q.push_back(ez);
    @(posedge clk);
    #1;
    expect_vld = (exp_q.size() != 0);
    chk({tag, ".sel"}, 8'(sel), 8'(esel));
    chk({tag, ".locked"}, 8'(locked), 8'(elk));
    chk({tag, ".sync_err"}, 8'(sync_err), 8'(eserr));
    chk({tag, ".vld"}, 8'(vld), 8'(expect_vld));
    if (vld && exp_q.size() != 0) last_z = exp_q.pop_front();
    chk({tag, ".z"}, 8'({z3, z2, z1, z0}), 8'(last_z));
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // basic frame 1,0,1,1
    step("f1s0", 1, 1, 1, 2'd1, 1, 0, 0, 4'h0);
    step("f1s1", 1, 0, 0, 2'd2, 1, 0, 0, 4'h0);
    step("f1s2", 1, 1, 0, 2'd3, 1, 0, 0, 4'h0);
    step("f1s3", 1, 1, 0, 2'd0, 1, 0, 1, 4'b1101);
    step("f1idle", 0, 0, 0, 2'd0, 1, 0, 0, 4'h0);

    // same frame with enable gaps; sel must freeze during en=0
    step("g_s0", 1, 1, 1, 2'd1, 1, 0, 0, 4'h0);
    step("g_h0", 0, 0, 1, 2'd1, 1, 0, 0, 4'h0);
    step("g_s1", 1, 0, 0, 2'd2, 1, 0, 0, 4'h0);
    step("g_h1", 0, 1, 1, 2'd2, 1, 0, 0, 4'h0);
    step("g_s2", 1, 1, 0, 2'd3, 1, 0, 0, 4'h0);
    step("g_h2", 0, 0, 1, 2'd3, 1, 0, 0, 4'h0);
    step("g_s3", 1, 1, 0, 2'd0, 1, 0, 1, 4'b1101);
    step("g_h3", 0, 0, 0, 2'd0, 1, 0, 0, 4'h0);

    // misaligned strobe at slot 2
    step("m_s0", 1, 1, 1, 2'd1, 1, 0, 0, 4'h0);
    step("m_s1", 1, 0, 0, 2'd2, 1, 0, 0, 4'h0);
    step("m_bad", 1, 0, 1, 2'd1, 1, 1, 0, 4'h0);
    step("m_r1", 1, 1, 0, 2'd2, 1, 0, 0, 4'h0);
    step("m_r2", 1, 1, 0, 2'd3, 1, 0, 0, 4'h0);
    step("m_r3", 1, 0, 0, 2'd0, 1, 0, 1, 4'b0110);

    // first missing strobe: frame still delivered
    step("l1_s0", 1, 1, 0, 2'd1, 1, 0, 0, 4'h0);
    step("l1_s1", 1, 1, 0, 2'd2, 1, 0, 0, 4'h0);
    step("l1_s2", 1, 0, 0, 2'd3, 1, 0, 0, 4'h0);
    step("l1_s3", 1, 0, 0, 2'd0, 1, 0, 1, 4'b0011);
    // second consecutive miss drops lock, z holds
    step("l2_s0", 1, 1, 0, 2'd0, 0, 0, 0, 4'h0);
    step("hunt_d", 1, 1, 0, 2'd0, 0, 0, 0, 4'h0);
    step("relock", 1, 0, 1, 2'd1, 1, 0, 0, 4'h0);
    step("rl_s1", 1, 1, 0, 2'd2, 1, 0, 0, 4'h0);
    step("rl_s2", 1, 0, 0, 2'd3, 1, 0, 0, 4'h0);
    step("rl_s3", 1, 1, 0, 2'd0, 1, 0, 1, 4'b1010);

    // reset mid-frame after slot 2, asserted between clock edges
    step("r_s0", 1, 1, 1, 2'd1, 1, 0, 0, 4'h0);
    step("r_s1", 1, 0, 0, 2'd2, 1, 0, 0, 4'h0);
    step("r_s2", 1, 1, 0, 2'd3, 1, 0, 0, 4'h0);
    #2;
    en    = 1'b1;
    din   = 1'b1;
    fs    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    last_z = 4'h0;
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // strobes with en=0 and fs=0 samples are ignored in HUNT
    step("h_off", 0, 1, 1, 2'd0, 0, 0, 0, 4'h0);
    step("h_nofs", 1, 1, 0, 2'd0, 0, 0, 0, 4'h0);
    step("h_lock", 1, 0, 1, 2'd1, 1, 0, 0, 4'h0);
    step("h_s1", 1, 0, 0, 2'd2, 1, 0, 0, 4'h0);
    step("h_s2", 1, 0, 0, 2'd3, 1, 0, 0, 4'h0);
    step("h_s3", 1, 1, 0, 2'd0, 1, 0, 1, 4'b1000);
    step("h_end", 0, 0, 0, 2'd0, 1, 0, 0, 4'h0);

    chk("queue_empty", 8'(exp_q.size()), 8'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
